// File: rtl/edge_event_rr_encoder.sv
// Rising-edge event queue with round-robin index encoder.
// Watches an 8-bit sticky capture vector, queues one pending event per newly
// set bit, and hands events out one at a time as a 3-bit index over val/rdy.
// A bit that fires again while its earlier event is still queued sets a
// sticky overflow flag.
module edge_event_rr_encoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [7:0] in_,
  output logic       out_val,
  input  logic       out_rdy,
  output logic [2:0] out_idx,
  output logic [7:0] overflow
);

  logic [7:0]  in_prev_q,  in_prev_d;
  logic [7:0]  pending_q,  pending_d;
  logic [2:0]  ptr_q,      ptr_d;
  logic        out_val_q,  out_val_d;
  logic [2:0]  out_idx_q,  out_idx_d;
  logic [7:0]  overflow_q, overflow_d;

  logic [7:0]  new_w;
  logic        free_w;
  logic        load_w;
  logic [15:0] pend_dbl_w;
  logic [7:0]  pend_rot_w;
  logic [2:0]  offset_w;
  logic [2:0]  sel_w;
  logic [7:0]  load_mask_w;

  assign new_w  = in_ & ~in_prev_q;
  assign free_w = ~out_val_q | out_rdy;
  assign load_w = free_w & (|pending_q);

  // Rotate pending so that bit 0 of the rotated view is the ptr position;
  // the lowest set bit of the rotated view is then the round-robin winner.
  assign pend_dbl_w = {pending_q, pending_q} >> ptr_q;
  assign pend_rot_w = pend_dbl_w[7:0];

  // Lowest set bit of the rotated pending vector (scan downward so the
  // lowest index is the last one to win).
  always_comb begin
    offset_w = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (pend_rot_w[k]) begin
        offset_w = k[2:0];
      end
    end
  end

  assign sel_w = ptr_q + offset_w;

  // One-hot of the selected source, only in a cycle that actually loads.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_load_mask
      assign load_mask_w[gi] = load_w && (sel_w == 3'(gi));
    end
  endgenerate

  // Next-state: soft clear wins over everything except the in_prev tracking.
  always_comb begin
    in_prev_d  = in_;
    pending_d  = pending_q;
    ptr_d      = ptr_q;
    out_val_d  = out_val_q;
    out_idx_d  = out_idx_q;
    overflow_d = overflow_q;
    if (clear) begin
      pending_d  = 8'd0;
      ptr_d      = 3'd0;
      out_val_d  = 1'b0;
      out_idx_d  = 3'd0;
      overflow_d = 8'd0;
    end else begin
      pending_d  = (pending_q & ~load_mask_w) | new_w;
      overflow_d = overflow_q | (new_w & pending_q & ~load_mask_w);
      if (free_w) begin
        out_val_d = load_w;
        if (load_w) begin
          out_idx_d = sel_w;
          ptr_d     = sel_w + 3'd1;
        end
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_prev_q  <= 8'd0;
      pending_q  <= 8'd0;
      ptr_q      <= 3'd0;
      out_val_q  <= 1'b0;
      out_idx_q  <= 3'd0;
      overflow_q <= 8'd0;
    end else begin
      in_prev_q  <= in_prev_d;
      pending_q  <= pending_d;
      ptr_q      <= ptr_d;
      out_val_q  <= out_val_d;
      out_idx_q  <= out_idx_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_val  = out_val_q;
  assign out_idx  = out_idx_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_edge_event_rr_encoder.sv
// Bench for edge_event_rr_encoder: directed scenarios feed a scoreboard of
// expected event indices that a monitor pops on each transfer, followed by a
// short randomized run against a cycle reference model.
module tb_edge_event_rr_encoder;

  logic       clk;
  logic       reset;
  logic       clear;
  logic [7:0] in_;
  logic       out_val;
  logic       out_rdy;
  logic [2:0] out_idx;
  logic [7:0] overflow;

  int n_vec;
  int n_bad;
  bit mon_en;
  int exp_q[$];

  edge_event_rr_encoder dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .in_      (in_),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_idx  (out_idx),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every transfer must match the next expected index.
  always @(negedge clk) begin
    if (mon_en && !reset && out_val && out_rdy) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL event_unexpected: got idx %0d, expected no event", out_idx);
      end else begin
        check("event_idx", int'(out_idx), exp_q.pop_front());
      end
    end
  end

  // Reference model state for the random phase.
  logic [7:0] m_prev, m_pend, m_ovf, m_lm, m_nw;
  int         m_ptr, m_idx, m_sel, m_pos;
  bit         m_val, m_free, m_found;
  logic [7:0] r_in;
  bit         r_rdy, r_clr;

  initial begin
    n_vec = 0; n_bad = 0; mon_en = 1'b1;
    reset = 1'b1; clear = 1'b0; in_ = 8'h00; out_rdy = 1'b1;
    repeat (3) tick();
    check("reset_out_val", out_val, 0);
    check("reset_out_idx", out_idx, 0);
    check("reset_overflow", overflow, 0);
    reset = 1'b0;

    // Single edge: visible two cycles after the rise, for one cycle only.
    tick();
    tick();
    in_ = 8'h01; exp_q.push_back(0);
    tick();
    check("single_n1_val", out_val, 0);
    tick();
    check("single_n2_val", out_val, 1);
    check("single_n2_idx", out_idx, 0);
    tick();
    check("single_n3_val", out_val, 0);
    check("single_overflow", overflow, 0);

    // Simultaneous edges after clear: idx 0 then idx 4.
    clear = 1'b1; tick(); clear = 1'b0;
    in_ = 8'h00; tick();
    in_ = 8'h11; exp_q.push_back(0); exp_q.push_back(4);
    tick();
    tick();
    check("simul_first_idx", out_idx, 0);
    tick();
    check("simul_second_val", out_val, 1);
    check("simul_second_idx", out_idx, 4);
    tick();
    check("simul_done_val", out_val, 0);
    check("simul_queue_drained", exp_q.size(), 0);

    // Round robin: after delivering 0, ptr=1 so bit 3 beats bit 0.
    clear = 1'b1; tick(); clear = 1'b0;
    in_ = 8'h00; tick();
    in_ = 8'h01; exp_q.push_back(0); tick();
    repeat (3) tick();
    in_ = 8'h00; tick();
    in_ = 8'h09; exp_q.push_back(3); exp_q.push_back(0); tick();
    repeat (4) tick();
    check("rr_done_val", out_val, 0);
    check("rr_queue_drained", exp_q.size(), 0);

    // Backpressure, hold stability and overflow.
    clear = 1'b1; tick(); clear = 1'b0;
    out_rdy = 1'b0;
    in_ = 8'h00; tick();
    in_ = 8'h01; tick();
    in_ = 8'h00; tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_val", out_val, 1);
      check("bp_hold_idx", out_idx, 0);
      tick();
    end
    in_ = 8'h01; tick();
    check("bp_first_repend_ovf", overflow, 8'h00);
    in_ = 8'h00; tick();
    in_ = 8'h01; tick();
    check("bp_overflow_set", overflow, 8'h01);
    check("bp_still_held_idx", out_idx, 0);
    exp_q.push_back(0); exp_q.push_back(0);
    in_ = 8'h00; out_rdy = 1'b1;
    repeat (4) tick();
    check("bp_done_val", out_val, 0);
    check("bp_overflow_sticky", overflow, 8'h01);
    check("bp_queue_drained", exp_q.size(), 0);

    // Clear with pending=0x55 and an event held in the output register.
    out_rdy = 1'b0;
    in_ = 8'h00; tick();
    in_ = 8'h01; tick();
    in_ = 8'h00; tick();
    in_ = 8'h55; tick();
    check("clr_pre_val", out_val, 1);
    check("clr_pre_overflow", overflow, 8'h01);
    clear = 1'b1; in_ = 8'hFF; tick(); clear = 1'b0;
    check("clr_post_val", out_val, 0);
    check("clr_post_overflow", overflow, 8'h00);
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("clr_hold_ff_val", out_val, 0);
    end
    in_ = 8'h00; tick();
    in_ = 8'h02; exp_q.push_back(1); tick();
    tick();
    check("clr_after_idx", out_idx, 1);
    repeat (2) tick();
    check("clr_after_done_val", out_val, 0);
    check("clr_queue_drained", exp_q.size(), 0);

    // Random phase, compared every cycle to the reference model.
    mon_en = 1'b0;
    m_prev = 8'h00; m_pend = 8'h00; m_ovf = 8'h00;
    m_ptr = 0; m_idx = 0; m_val = 1'b0;
    for (int i = 0; i < 60; i++) begin
      r_in  = 8'($urandom);
      r_rdy = ($urandom_range(0, 1) == 1);
      r_clr = (i == 0) || ($urandom_range(0, 11) == 0);
      in_ = r_in; out_rdy = r_rdy; clear = r_clr;
      m_nw = r_in & ~m_prev;
      if (r_clr) begin
        m_pend = 8'h00; m_ptr = 0; m_val = 1'b0; m_idx = 0; m_ovf = 8'h00;
      end else begin
        m_free = !m_val || r_rdy;
        m_found = 1'b0; m_sel = 0; m_lm = 8'h00;
        if (m_free) begin
          for (int k = 0; k < 8; k++) begin
            m_pos = (m_ptr + k) % 8;
            if (!m_found && m_pend[m_pos]) begin
              m_found = 1'b1;
              m_sel = m_pos;
            end
          end
          if (m_found) begin
            m_lm[m_sel] = 1'b1;
            m_val = 1'b1;
            m_idx = m_sel;
            m_ptr = (m_sel + 1) % 8;
          end else begin
            m_val = 1'b0;
          end
        end
        m_ovf  = m_ovf | (m_nw & m_pend & ~m_lm);
        m_pend = (m_pend & ~m_lm) | m_nw;
      end
      m_prev = r_in;
      tick();
      check("rand_out_val", out_val, m_val);
      if (m_val) check("rand_out_idx", out_idx, m_idx);
      check("rand_overflow", overflow, m_ovf);
    end
    clear = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
